// File: rtl/bsg_manycore_reset_sequencer.sv
// Staggered multi-channel reset/bring-up sequencer with tag-done collection and timeout.
// Optional bring-up cycle counter enabled by defining BSG_RESET_SEQ_CYCLE_STATS_EN.
module bsg_manycore_reset_sequencer #(
  parameter int unsigned num_channels_p     = 4,
  parameter int unsigned hold_cycles_p      = 16,
  parameter int unsigned stagger_cycles_p   = 4,
  parameter int unsigned done_sync_stages_p = 3,
  parameter int unsigned timeout_cycles_p   = 4096
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_i,
  input  logic [num_channels_p-1:0] tag_done_i,
  output logic [num_channels_p-1:0] chan_reset_o,
  output logic                      host_reset_o,
  output logic                      all_done_o,
  output logic                      timeout_o,
  output logic [num_channels_p-1:0] pending_o,
  output logic [2:0]                state_o
`ifdef BSG_RESET_SEQ_CYCLE_STATS_EN
  ,
  output logic [31:0]               bringup_cycles_o
`endif
);

  localparam int unsigned HoldW = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;
  localparam int unsigned StagW = (stagger_cycles_p > 1) ? $clog2(stagger_cycles_p) : 1;
  localparam int unsigned IdxW  = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
  localparam int unsigned SyncW = (done_sync_stages_p > 1) ? $clog2(done_sync_stages_p) : 1;
  localparam int unsigned ToW   = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;

  localparam logic [HoldW-1:0] HoldLast = HoldW'(hold_cycles_p - 1);
  localparam logic [StagW-1:0] StagLast =
    StagW'((stagger_cycles_p > 0) ? stagger_cycles_p - 1 : 0);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(num_channels_p - 1);
  localparam logic [SyncW-1:0] SyncLast = SyncW'(done_sync_stages_p - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(timeout_cycles_p - 1);

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StStagger  = 3'd1,
    StWaitDone = 3'd2,
    StSync     = 3'd3,
    StRun      = 3'd4,
    StError    = 3'd5
  } state_e;

  state_e                    state_q;
  logic [HoldW-1:0]          hold_cnt_q;
  logic [StagW-1:0]          stag_cnt_q;
  logic [IdxW-1:0]           idx_q;
  logic [IdxW-1:0]           idx_nxt;
  logic [ToW-1:0]            to_cnt_q;
  logic [SyncW-1:0]          sync_cnt_q;
  logic [num_channels_p-1:0] chan_reset_q;
  logic [num_channels_p-1:0] done_q;
  logic [num_channels_p-1:0] done_nxt;
  logic [num_channels_p-1:0] frozen_q;
  logic                      go_hold;

  always_comb begin
    // A done level only counts once the channel is out of reset.
    done_nxt = done_q | (tag_done_i & ~chan_reset_q);
    idx_nxt  = idx_q + 1'b1;
    go_hold  = 1'b0;
    case (state_q)
      StRun, StError:                        go_hold = start_i;
      StHold, StStagger, StWaitDone, StSync: go_hold = 1'b0;
      default:                               go_hold = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || go_hold) begin
      state_q      <= StHold;
      hold_cnt_q   <= '0;
      stag_cnt_q   <= '0;
      idx_q        <= '0;
      to_cnt_q     <= '0;
      sync_cnt_q   <= '0;
      chan_reset_q <= '1;
      done_q       <= '0;
      frozen_q     <= '0;
    end else begin
      done_q <= done_nxt;
      case (state_q)
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            hold_cnt_q <= '0;
            stag_cnt_q <= '0;
            idx_q      <= '0;
            to_cnt_q   <= '0;
            if (stagger_cycles_p == 0) begin
              chan_reset_q <= '0;
              state_q      <= StStagger;
            end else begin
              chan_reset_q[0] <= 1'b0;
              state_q         <= (num_channels_p == 1) ? StWaitDone : StStagger;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        StStagger: begin
          if (stagger_cycles_p == 0) begin
            to_cnt_q <= '0;
            state_q  <= StWaitDone;
          end else if (stag_cnt_q == StagLast) begin
            stag_cnt_q            <= '0;
            idx_q                 <= idx_nxt;
            chan_reset_q[idx_nxt] <= 1'b0;
            if (idx_nxt == IdxLast) begin
              to_cnt_q <= '0;
              state_q  <= StWaitDone;
            end
          end else begin
            stag_cnt_q <= stag_cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (&done_nxt) begin
            sync_cnt_q <= '0;
            state_q    <= StSync;
          end else if (to_cnt_q == ToLast) begin
            frozen_q <= ~done_nxt;
            state_q  <= StError;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        StSync: begin
          if (sync_cnt_q == SyncLast) begin
            state_q <= StRun;
          end else begin
            sync_cnt_q <= sync_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pending_o = '0;
    if (state_q == StWaitDone) begin
      pending_o = ~done_q;
    end else if (state_q == StError) begin
      pending_o = frozen_q;
    end
  end

  assign chan_reset_o = chan_reset_q;
  assign host_reset_o = (state_q != StRun);
  assign all_done_o   = (state_q == StRun);
  assign timeout_o    = (state_q == StError);
  assign state_o      = state_q;

`ifdef BSG_RESET_SEQ_CYCLE_STATS_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || go_hold) begin
      cycles_q <= '0;
    end else if (state_q != StRun && state_q != StError && cycles_q != '1) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign bringup_cycles_o = cycles_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && state_q == StSync && sync_cnt_q == SyncLast) begin
      $display("[%m] bring-up took %0d cycles", (cycles_q == '1) ? cycles_q : cycles_q + 32'd1);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_bsg_manycore_reset_sequencer.sv
// Bench for bsg_manycore_reset_sequencer: a staggered (default) and an unstaggered instance
// checked every cycle against a time-based model, plus hand-computed literal checkpoints.
module tb_bsg_manycore_reset_sequencer;

  localparam int N = 4;
  localparam int H = 16;
  localparam int D = 3;
  localparam int T = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] tag;

  logic [3:0] chan_rst [2];
  logic       host_rst [2];
  logic       all_done [2];
  logic       tmo      [2];
  logic [3:0] pending  [2];
  logic [2:0] state    [2];
`ifdef BSG_RESET_SEQ_CYCLE_STATS_EN
  logic [31:0] bcyc    [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bsg_manycore_reset_sequencer #(
    .num_channels_p(N), .hold_cycles_p(H), .stagger_cycles_p(4),
    .done_sync_stages_p(D), .timeout_cycles_p(T)
  ) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .tag_done_i(tag),
    .chan_reset_o(chan_rst[0]), .host_reset_o(host_rst[0]), .all_done_o(all_done[0]),
    .timeout_o(tmo[0]), .pending_o(pending[0]), .state_o(state[0])
`ifdef BSG_RESET_SEQ_CYCLE_STATS_EN
    , .bringup_cycles_o(bcyc[0])
`endif
  );

  bsg_manycore_reset_sequencer #(
    .num_channels_p(N), .hold_cycles_p(H), .stagger_cycles_p(0),
    .done_sync_stages_p(D), .timeout_cycles_p(T)
  ) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .tag_done_i(tag),
    .chan_reset_o(chan_rst[1]), .host_reset_o(host_rst[1]), .all_done_o(all_done[1]),
    .timeout_o(tmo[1]), .pending_o(pending[1]), .state_o(state[1])
`ifdef BSG_RESET_SEQ_CYCLE_STATS_EN
    , .bringup_cycles_o(bcyc[1])
`endif
  );

  // ---------------- model: phases derived from time since HOLD entry ----------------
  function automatic int stag(int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic int wait_start(int i);
    return (stag(i) == 0) ? H + 1 : H + (N - 1) * stag(i);
  endfunction

  function automatic logic [3:0] rel_mask(int i, int t);
    logic [3:0] m;
    for (int k = 0; k < N; k++) m[k] = (t >= H + k * stag(i));
    return m;
  endfunction

  bit         m_valid = 1'b0;
  int         m_phase [2];
  int         m_t     [2];
  int         m_w     [2];
  int         m_s     [2];
  int         m_cyc   [2];
  logic [3:0] m_done  [2];
  logic [3:0] m_frz   [2];

  always @(posedge clk) begin
    logic [3:0] dn;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] = 0; m_t[i] = 0; m_done[i] = '0; m_frz[i] = '0; m_cyc[i] = 0;
        m_valid    = 1'b1;
      end else if (m_valid) begin
        dn = m_done[i] | (tag & ((m_phase[i] == 0) ? 4'b0000 : rel_mask(i, m_t[i])));
        m_done[i] = dn;
        if (m_phase[i] != 4 && m_phase[i] != 5) m_cyc[i]++;
        case (m_phase[i])
          0, 1: begin
            m_t[i]++;
            if (m_t[i] < H) m_phase[i] = 0;
            else if (m_t[i] < wait_start(i)) m_phase[i] = 1;
            else begin m_phase[i] = 2; m_w[i] = 0; end
          end
          2: begin
            if (&dn) begin m_phase[i] = 3; m_s[i] = 0; end
            else if (m_w[i] == T - 1) begin m_phase[i] = 5; m_frz[i] = ~dn; end
            else m_w[i]++;
          end
          3: begin
            if (m_s[i] == D - 1) m_phase[i] = 4;
            else m_s[i]++;
          end
          default: begin
            if (start) begin
              m_phase[i] = 0; m_t[i] = 0; m_done[i] = '0; m_frz[i] = '0; m_cyc[i] = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, i, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e_chan, e_pend;
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        e_chan = (m_phase[i] == 0) ? 4'b1111 : ~rel_mask(i, m_t[i]);
        e_pend = (m_phase[i] == 2) ? ~m_done[i] : (m_phase[i] == 5) ? m_frz[i] : 4'b0000;
        chk("chan_reset", i, 32'(chan_rst[i]), 32'(e_chan));
        chk("host_reset", i, 32'(host_rst[i]), 32'(m_phase[i] != 4));
        chk("all_done",   i, 32'(all_done[i]), 32'(m_phase[i] == 4));
        chk("timeout",    i, 32'(tmo[i]),      32'(m_phase[i] == 5));
        chk("pending",    i, 32'(pending[i]),  32'(e_pend));
        chk("state",      i, 32'(state[i]),    32'(m_phase[i]));
`ifdef BSG_RESET_SEQ_CYCLE_STATS_EN
        chk("bringup_cycles", i, bcyc[i], 32'(m_cyc[i]));
`endif
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus with literal checkpoints ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; tag = 4'b1111;
    step(3);
    rst_n = 1'b1;                                   // cycle 0 of HOLD
    chk("lit_rst_state", 0, 32'(state[0]), 32'd0);
    chk("lit_rst_chan", 0, 32'(chan_rst[0]), 32'hf);
    chk("lit_rst_host", 0, 32'(host_rst[0]), 32'd1);
    chk("lit_rst_pending", 0, 32'(pending[0]), 32'd0);
    step(15);                                       // cycle 15
    chk("lit_c15_chan", 0, 32'(chan_rst[0]), 32'hf);
    chk("lit_c15_chan_s0", 1, 32'(chan_rst[1]), 32'hf);
    step(1);                                        // cycle 16
    chk("lit_c16_chan", 0, 32'(chan_rst[0]), 32'he);
    chk("lit_c16_chan_s0", 1, 32'(chan_rst[1]), 32'h0);
    chk("lit_c16_state_s0", 1, 32'(state[1]), 32'd1);
    step(1);                                        // cycle 17
    chk("lit_c17_state_s0", 1, 32'(state[1]), 32'd2);
    step(3);                                        // cycle 20
    chk("lit_c20_chan", 0, 32'(chan_rst[0]), 32'hc);
    step(8);                                        // cycle 28
    chk("lit_c28_chan", 0, 32'(chan_rst[0]), 32'h0);
    chk("lit_c28_state", 0, 32'(state[0]), 32'd2);
    step(1);                                        // cycle 29
    chk("lit_c29_state", 0, 32'(state[0]), 32'd3);
    step(2);                                        // cycle 31
    chk("lit_c31_host", 0, 32'(host_rst[0]), 32'd1);
    step(1);                                        // cycle 32
    chk("lit_c32_state", 0, 32'(state[0]), 32'd4);
    chk("lit_c32_host", 0, 32'(host_rst[0]), 32'd0);
    chk("lit_c32_all_done", 0, 32'(all_done[0]), 32'd1);
`ifdef BSG_RESET_SEQ_CYCLE_STATS_EN
    chk("lit_bringup", 0, bcyc[0], 32'd32);
    chk("lit_bringup_s0", 1, bcyc[1], 32'd21);
`endif

    // Channel 2 pulses only while still held in reset -> timeout.
    tag = 4'b1011; start = 1'b1;
    step(1);                                        // cycle 0
    start = 1'b0;
    step(5);                                        // cycle 5
    tag = 4'b1111;
    step(1);                                        // cycle 6
    tag = 4'b1011; start = 1'b1;                    // ignored in HOLD
    step(1);
    start = 1'b0;
    step(93);                                       // cycle 100, WAIT_DONE
    start = 1'b1;                                   // ignored in WAIT_DONE
    step(1);
    start = 1'b0;
    step(4022);                                     // cycle 4123
    chk("lit_c4123_state", 0, 32'(state[0]), 32'd2);
    step(1);                                        // cycle 4124
    chk("lit_err_state", 0, 32'(state[0]), 32'd5);
    chk("lit_err_timeout", 0, 32'(tmo[0]), 32'd1);
    chk("lit_err_pending", 0, 32'(pending[0]), 32'h4);
    chk("lit_err_host", 0, 32'(host_rst[0]), 32'd1);
    tag = 4'b1111;                                  // late done stays in ERROR
    step(3);
    chk("lit_err_late_state", 0, 32'(state[0]), 32'd5);
    chk("lit_err_late_pending", 0, 32'(pending[0]), 32'h4);

    // Restart from ERROR.
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("lit_restart_state", 0, 32'(state[0]), 32'd0);
    chk("lit_restart_chan", 0, 32'(chan_rst[0]), 32'hf);
    chk("lit_restart_timeout", 0, 32'(tmo[0]), 32'd0);
    step(32);
    chk("lit_restart_run", 0, 32'(state[0]), 32'd4);

    // Channel 1 pulses once after release; others report late.
    tag = 4'b0000; start = 1'b1;
    step(1);
    start = 1'b0;
    step(22);                                       // cycle 22
    tag = 4'b0010;
    step(1);
    tag = 4'b0000;
    step(17);                                       // cycle 40
    chk("lit_sticky_pending", 0, 32'(pending[0]), 32'hd);
    tag = 4'b1101;
    step(1);                                        // cycle 41
    chk("lit_sticky_sync", 0, 32'(state[0]), 32'd3);
    step(3);                                        // cycle 44
    chk("lit_sticky_run", 0, 32'(state[0]), 32'd4);
    chk("lit_sticky_timeout", 0, 32'(tmo[0]), 32'd0);

    // Reset mid-STAGGER after two channels released.
    tag = 4'b1111; start = 1'b1;
    step(1);
    start = 1'b0;
    step(21);                                       // cycle 21
    chk("lit_mid_chan", 0, 32'(chan_rst[0]), 32'hc);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("lit_abort_state", 0, 32'(state[0]), 32'd0);
    chk("lit_abort_chan", 0, 32'(chan_rst[0]), 32'hf);
    chk("lit_abort_host", 0, 32'(host_rst[0]), 32'd1);
    step(32);
    chk("lit_abort_run", 0, 32'(state[0]), 32'd4);
`ifdef BSG_RESET_SEQ_CYCLE_STATS_EN
    chk("lit_abort_bringup", 0, bcyc[0], 32'd32);
`endif
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
